// File: rtl/dec_3b_pipe.sv
// dec_3b_pipe: decodes a 3-bit index into an 8-bit one-hot word. A 2-entry
// FIFO (head + skid) sits between the input and output valid/ready
// handshakes.
//
// Ports:
//   clk_i        clock; all state updates on its rising edge
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   upstream index valid
//   in_ready_o   registered; block can accept an index this cycle
//   data_i[2:0]  binary index
//   out_valid_o  head one-hot word valid
//   out_ready_i  downstream accepts the head word
//   data_o[7:0]  registered one-hot decode of the head index, 8'h00 when idle
//   clear_i      synchronous clear of mask_o          (DEC_3B_MASK_EN only)
//   mask_o[7:0]  OR of all words delivered since clear (DEC_3B_MASK_EN only)
//
// Build option: define DEC_3B_MASK_EN to add the delivered-word mask.
module dec_3b_pipe (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [2:0] data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] data_o
`ifdef DEC_3B_MASK_EN
  ,
  input  logic       clear_i,
  output logic [7:0] mask_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     state_p0, state_nxt;
  logic [7:0] head_p0, head_nxt;   // head entry, kept already decoded
  logic [2:0] skid_p0, skid_nxt;   // second entry, kept as a raw index
  logic       rdy_p0;
  logic       push, pop;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'b0000_0001 << idx;
  endfunction

  // rdy_p0 is 0 in FULL, so in_valid_i is naturally ignored there.
  assign push        = in_valid_i & rdy_p0;
  assign pop         = (state_p0 != EMPTY) & out_ready_i;
  assign in_ready_o  = rdy_p0;
  assign out_valid_o = (state_p0 != EMPTY);
  assign data_o      = head_p0;

  always_comb begin
    state_nxt = state_p0;
    head_nxt  = head_p0;
    skid_nxt  = skid_p0;
    case (state_p0)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          head_nxt  = onehot(data_i);
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = onehot(data_i);
        end else if (push) begin
          state_nxt = FULL;
          skid_nxt  = data_i;
        end else if (pop) begin
          state_nxt = EMPTY;
          head_nxt  = 8'h00;    // idle output must read as zero
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt = ONE;
          head_nxt  = onehot(skid_p0);
        end
      end
      default: begin
        state_nxt = EMPTY;
        head_nxt  = 8'h00;
      end
    endcase
  end

  // ---- stage p0: FIFO state, head word and ready register ----
  // Ready is registered from the next state, so it never follows out_ready_i
  // combinationally. It stays low during reset and rises at the first edge
  // after release, when no transfer can occur because it was still low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_p0 <= EMPTY;
      head_p0  <= 8'h00;
      rdy_p0   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      head_p0  <= head_nxt;
      rdy_p0   <= (state_nxt != FULL);
    end
  end

  // The skid index is only read in FULL, so it needs no reset.
  always_ff @(posedge clk_i) begin
    skid_p0 <= skid_nxt;
  end

`ifdef DEC_3B_MASK_EN
  logic [7:0] mask_p0;

  // A clear together with a delivery starts the mask from that word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask_p0 <= 8'h00;
    end else if (pop) begin
      mask_p0 <= clear_i ? head_p0 : (mask_p0 | head_p0);
    end else if (clear_i) begin
      mask_p0 <= 8'h00;
    end
  end

  assign mask_o = mask_p0;
`endif

endmodule

// File: tb/tb_dec_3b_pipe.sv
// Testbench for dec_3b_pipe. A queue of accepted indices is the reference
// model; expected outputs come from the queue contents.
module tb_dec_3b_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       clear;
`ifdef DEC_3B_MASK_EN
  logic [7:0] mask;
`endif

  int         n_cmp = 0;
  int         n_err = 0;

  logic [2:0] q[$];
  logic       exp_ready;
  logic [7:0] exp_mask;

  dec_3b_pipe dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (data_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_out)
`ifdef DEC_3B_MASK_EN
    ,
    .clear_i     (clear),
    .mask_o      (mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_word();
    return (q.size() > 0) ? 8'(32'd1 << q[0]) : 8'h00;
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check_eq("data_o", 32'(data_out), 32'(exp_word()));
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
`ifdef DEC_3B_MASK_EN
    check_eq("mask_o", 32'(mask), 32'(exp_mask));
`endif
  endtask

  // One clock: check at the falling edge, drive inputs, then advance the
  // model at the rising edge using the handshake the spec defines.
  task automatic cycle(input logic v, input logic [2:0] d, input logic r, input logic c);
    logic       push, pop;
    logic [7:0] head;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    data_in   = d;
    out_ready = r;
    clear     = c;
    push = v && exp_ready;
    pop  = (q.size() > 0) && r;
    head = exp_word();
    @(posedge clk);
    if (pop) begin
      exp_mask = c ? head : (exp_mask | head);
      void'(q.pop_front());
    end else if (c) begin
      exp_mask = 8'h00;
    end
    if (push) q.push_back(d);
    exp_ready = (q.size() != 2);
  endtask

  // Asserts reset away from the clock edge, checks the asynchronous effect,
  // and releases just after a rising edge.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
`ifdef DEC_3B_MASK_EN
    check_eq("rst_mask", 32'(mask), 32'd0);
`endif
    q.delete();
    exp_ready = 1'b0;
    exp_mask  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_data", 32'(data_out), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 3'd0;
    out_ready = 1'b0;
    clear     = 1'b0;
    exp_ready = 1'b0;
    exp_mask  = 8'h00;
    apply_reset();

    // Single index with both sides ready: 5 -> 8'h20.
    cycle(1'b1, 3'd5, 1'b1, 1'b0);
    cycle(1'b1, 3'd5, 1'b1, 1'b0);
    #1;
    check_eq("r027_valid", 32'(out_valid), 32'd1);
    check_eq("r027_data", 32'(data_out), 32'h20);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    // Back-pressure: 0 and 7 fill the FIFO, 3 is held until space frees.
    cycle(1'b1, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b0);
    cycle(1'b1, 3'd3, 1'b0, 1'b0);
    #1;
    check_eq("r028_ready", 32'(in_ready), 32'd0);
    check_eq("r028_hold", 32'(data_out), 32'h01);
    cycle(1'b1, 3'd3, 1'b0, 1'b0);
    cycle(1'b1, 3'd3, 1'b1, 1'b0);
    #1;
    check_eq("r028_second", 32'(data_out), 32'h80);
    cycle(1'b1, 3'd3, 1'b1, 1'b0);
    #1;
    check_eq("r028_third", 32'(data_out), 32'h08);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    // Streaming 0..7 repeatedly: one word per cycle, no gaps.
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 3'(i % 8), 1'b1, 1'b0);
      if (i > 0) begin
        #1;
        check_eq("stream_data", 32'(data_out), 32'd1 << (i % 8));
      end
    end
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    // Reset while FULL holding 2 and 4: everything is discarded.
    cycle(1'b1, 3'd2, 1'b0, 1'b0);
    cycle(1'b1, 3'd4, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 1'b0, 1'b0);
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b1, 1'b0);
    #1;
    check_eq("r030_stale", 32'(out_valid), 32'd0);

`ifdef DEC_3B_MASK_EN
    // Mask: 1 and 6 give 8'h42; clear with delivery of 3 gives 8'h08;
    // clear alone gives 8'h00.
    cycle(1'b1, 3'd1, 1'b1, 1'b0);
    cycle(1'b1, 3'd6, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    #1;
    check_eq("r031_or", 32'(mask), 32'h42);
    cycle(1'b1, 3'd3, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b1);
    #1;
    check_eq("r031_clr_xfer", 32'(mask), 32'h08);
    cycle(1'b0, 3'd0, 1'b1, 1'b1);
    #1;
    check_eq("r031_clr", 32'(mask), 32'h00);
`endif

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
      if (i % 1000 == 999) apply_reset();
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
